// File: rtl/opl3_pkg.sv
// Shared OPL3 constants: slot geometry and the operator-slot sequencer state encoding.
package opl3_pkg;

   localparam int BANK_NUM_WIDTH         = 1;
   localparam int OP_NUM_WIDTH           = 5;
   localparam int NUM_BANKS              = 2;
   localparam int NUM_OPERATORS_PER_BANK = 18;

   typedef enum logic [1:0] {
      SEQ_IDLE  = 2'd0,
      SEQ_ISSUE = 2'd1,
      SEQ_GAP   = 2'd2,
      SEQ_FLUSH = 2'd3
   } seq_state_t;

endpackage

// File: rtl/op_slot_sequencer.sv
// Walks all operator slots of both banks once per sample tick, spacing the slot
// strobes evenly and signalling done after a fixed flush interval.
//
// state | meaning
// IDLE  | waiting for an enabled sample tick; bank/op held at 0
// ISSUE | slot_valid high for the slot shown on bank_num/op_num
// GAP   | spacing wait between two slot issues
// FLUSH | last slot issued, counting down to done
module op_slot_sequencer
   import opl3_pkg::*;
#(
   parameter int OP_SPACING   = 4,
   parameter int FLUSH_CYCLES = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      sample_clk_en,
   input  logic                      enable,
   input  logic                      overrun_clr,
   output logic                      slot_valid,
   output logic [BANK_NUM_WIDTH-1:0] bank_num,
   output logic [OP_NUM_WIDTH-1:0]   op_num,
   output logic                      last_slot,
   output logic                      busy,
   output logic                      done,
   output logic                      overrun
);

   localparam logic [1:0] ST_IDLE  = SEQ_IDLE;
   localparam logic [1:0] ST_ISSUE = SEQ_ISSUE;
   localparam logic [1:0] ST_GAP   = SEQ_GAP;
   localparam logic [1:0] ST_FLUSH = SEQ_FLUSH;

   localparam logic [BANK_NUM_WIDTH-1:0] LAST_BANK = BANK_NUM_WIDTH'(NUM_BANKS - 1);
   localparam logic [OP_NUM_WIDTH-1:0]   LAST_OP   = OP_NUM_WIDTH'(NUM_OPERATORS_PER_BANK - 1);

   // Both waits are entered after one cycle already spent in ISSUE, hence the -2.
   localparam logic [3:0] GAP_LOAD   = (OP_SPACING > 1)   ? 4'(OP_SPACING - 2)   : 4'd0;
   localparam logic [4:0] FLUSH_LOAD = (FLUSH_CYCLES > 1) ? 5'(FLUSH_CYCLES - 2) : 5'd0;

   logic [1:0]                state;
   logic [1:0]                state_nxt;
   logic [3:0]                gap_cnt;
   logic [4:0]                flush_cnt;
   logic [BANK_NUM_WIDTH-1:0] bank_nxt;
   logic [OP_NUM_WIDTH-1:0]   op_nxt;
   logic                      tick_ok;
   logic                      at_last;

   assign tick_ok = sample_clk_en && enable;
   assign at_last = (bank_num == LAST_BANK) && (op_num == LAST_OP);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (tick_ok) state_nxt = ST_ISSUE;
         ST_ISSUE: begin
            if (at_last)
               state_nxt = (FLUSH_CYCLES == 1) ? ST_IDLE : ST_FLUSH;
            else
               state_nxt = (OP_SPACING == 1) ? ST_ISSUE : ST_GAP;
         end
         ST_GAP:   if (gap_cnt == 4'd0) state_nxt = ST_ISSUE;
         ST_FLUSH: if (flush_cnt == 5'd0) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // The bank/op registers double as the slot counter; IDLE already holds 0/0.
   always_comb begin
      bank_nxt = bank_num;
      op_nxt   = op_num;
      if (state_nxt == ST_IDLE) begin
         bank_nxt = '0;
         op_nxt   = '0;
      end else if (state_nxt == ST_ISSUE && state != ST_IDLE) begin
         if (op_num == LAST_OP) begin
            op_nxt   = '0;
            bank_nxt = bank_num + BANK_NUM_WIDTH'(1);
         end else begin
            op_nxt = op_num + OP_NUM_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         gap_cnt    <= 4'd0;
         flush_cnt  <= 5'd0;
         bank_num   <= '0;
         op_num     <= '0;
         slot_valid <= 1'b0;
         last_slot  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         state      <= state_nxt;
         bank_num   <= bank_nxt;
         op_num     <= op_nxt;
         slot_valid <= (state_nxt == ST_ISSUE);
         last_slot  <= (state_nxt == ST_ISSUE) && (bank_nxt == LAST_BANK) && (op_nxt == LAST_OP);
         busy       <= (state_nxt != ST_IDLE);
         done       <= (state_nxt == ST_IDLE) && (state != ST_IDLE);

         if (state_nxt == ST_GAP && state != ST_GAP)
            gap_cnt <= GAP_LOAD;
         else if (gap_cnt != 4'd0)
            gap_cnt <= gap_cnt - 4'd1;

         if (state_nxt == ST_FLUSH && state != ST_FLUSH)
            flush_cnt <= FLUSH_LOAD;
         else if (flush_cnt != 5'd0)
            flush_cnt <= flush_cnt - 5'd1;

         // A new overrun outranks a simultaneous clear.
         if (tick_ok && state != ST_IDLE)
            overrun <= 1'b1;
         else if (overrun_clr)
            overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_op_slot_sequencer.sv
// Bench for op_slot_sequencer: default and OP_SPACING=1/FLUSH_CYCLES=1 instances
// on shared inputs, a per-cycle timing model, directed vectors and random traffic.
module tb_op_slot_sequencer;
   import opl3_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic sample_clk_en = 1'b0;
   logic enable = 1'b0;
   logic overrun_clr = 1'b0;

   logic                      sv_w[2];
   logic                      last_w[2];
   logic                      busy_w[2];
   logic                      done_w[2];
   logic                      ovr_w[2];
   logic [BANK_NUM_WIDTH-1:0] bank_w[2];
   logic [OP_NUM_WIDTH-1:0]   op_w[2];

   always #5 clk = ~clk;

   op_slot_sequencer #(.OP_SPACING(4), .FLUSH_CYCLES(8)) dut (
      .clk(clk), .reset(reset), .sample_clk_en(sample_clk_en), .enable(enable),
      .overrun_clr(overrun_clr), .slot_valid(sv_w[0]), .bank_num(bank_w[0]),
      .op_num(op_w[0]), .last_slot(last_w[0]), .busy(busy_w[0]), .done(done_w[0]),
      .overrun(ovr_w[0]));

   op_slot_sequencer #(.OP_SPACING(1), .FLUSH_CYCLES(1)) dut_fast (
      .clk(clk), .reset(reset), .sample_clk_en(sample_clk_en), .enable(enable),
      .overrun_clr(overrun_clr), .slot_valid(sv_w[1]), .bank_num(bank_w[1]),
      .op_num(op_w[1]), .last_slot(last_w[1]), .busy(busy_w[1]), .done(done_w[1]),
      .overrun(ovr_w[1]));

   int n_checks = 0;
   int n_fail = 0;

   task automatic chk(input string name, input int inst, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", name, inst, $time, act, exp);
      end
   endtask

   // Reference model: a sequence is just its start cycle; every output follows
   // from the elapsed time t with plain arithmetic.
   typedef struct {
      logic sv;
      int   bank;
      int   op;
      logic last;
      logic busy;
      logic done;
   } exp_t;

   bit m_act[2];
   int m_start[2];
   bit m_ovr[2];
   int mcyc = 0;

   function automatic exp_t model_out(int i, int c);
      exp_t e;
      int sp, fl, last_t, t, idx;
      e = '{default: 0};
      sp = (i == 0) ? 4 : 1;
      fl = (i == 0) ? 8 : 1;
      last_t = 1 + 35 * sp;
      if (m_act[i]) begin
         t = c - m_start[i];
         if (t <= last_t) begin
            idx    = (t - 1) / sp;
            e.sv   = ((t - 1) % sp) == 0;
            e.bank = idx / 18;
            e.op   = idx % 18;
            e.last = e.sv && (idx == 35);
            e.busy = 1'b1;
         end else if (t < last_t + fl) begin
            e.bank = 1;
            e.op   = 17;
            e.busy = 1'b1;
         end else begin
            e.done = (t == last_t + fl);
         end
      end
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      bit ov_set;
      mcyc++;
      for (int i = 0; i < 2; i++) begin
         e = model_out(i, mcyc);
         if (reset) begin
            e = '{default: 0};
            m_act[i] = 1'b0;
            m_ovr[i] = 1'b0;
         end
         chk("m_slot_valid", i, 8'(sv_w[i]), 8'(e.sv));
         chk("m_bank_num", i, 8'(bank_w[i]), 8'(e.bank));
         chk("m_op_num", i, 8'(op_w[i]), 8'(e.op));
         chk("m_last_slot", i, 8'(last_w[i]), 8'(e.last));
         chk("m_busy", i, 8'(busy_w[i]), 8'(e.busy));
         chk("m_done", i, 8'(done_w[i]), 8'(e.done));
         chk("m_overrun", i, 8'(ovr_w[i]), 8'(m_ovr[i]));
         if (!reset) begin
            if (m_act[i] && e.done) m_act[i] = 1'b0;
            ov_set = sample_clk_en && enable && e.busy;
            if (sample_clk_en && enable && !e.busy) begin
               m_act[i]   = 1'b1;
               m_start[i] = mcyc;
            end
            if (ov_set) m_ovr[i] = 1'b1;
            else if (overrun_clr) m_ovr[i] = 1'b0;
         end
      end
   end

   typedef struct {
      int   cyc;
      logic sv;
      int   bank;
      int   op;
      logic last;
      logic busy;
      logic done;
   } vec_t;

   vec_t tbl[10];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int n);
      sample_clk_en = 1'b0;
      overrun_clr   = 1'b0;
      for (int k = 0; k < n; k++) step();
      overrun_clr = 1'b1;
      step();
      overrun_clr = 1'b0;
   endtask

   initial begin
      int p0, p1;
      tbl[0] = '{cyc: 1,   sv: 1, bank: 0, op: 0,  last: 0, busy: 1, done: 0};
      tbl[1] = '{cyc: 2,   sv: 0, bank: 0, op: 0,  last: 0, busy: 1, done: 0};
      tbl[2] = '{cyc: 5,   sv: 1, bank: 0, op: 1,  last: 0, busy: 1, done: 0};
      tbl[3] = '{cyc: 72,  sv: 0, bank: 0, op: 17, last: 0, busy: 1, done: 0};
      tbl[4] = '{cyc: 73,  sv: 1, bank: 1, op: 0,  last: 0, busy: 1, done: 0};
      tbl[5] = '{cyc: 141, sv: 1, bank: 1, op: 17, last: 1, busy: 1, done: 0};
      tbl[6] = '{cyc: 142, sv: 0, bank: 1, op: 17, last: 0, busy: 1, done: 0};
      tbl[7] = '{cyc: 148, sv: 0, bank: 1, op: 17, last: 0, busy: 1, done: 0};
      tbl[8] = '{cyc: 149, sv: 0, bank: 0, op: 0,  last: 0, busy: 0, done: 1};
      tbl[9] = '{cyc: 150, sv: 0, bank: 0, op: 0,  last: 0, busy: 0, done: 0};

      step();
      step();
      chk("reset_busy", 0, 8'(busy_w[0]), 8'd0);
      chk("reset_overrun", 0, 8'(ovr_w[0]), 8'd0);
      reset = 1'b0;
      step();

      // Nominal sequence on both instances; tick in cycle 0.
      enable = 1'b1;
      sample_clk_en = 1'b1;
      p0 = 0;
      p1 = 0;
      for (int c = 1; c <= 150; c++) begin
         step();
         sample_clk_en = 1'b0;
         if (sv_w[0]) p0++;
         if (sv_w[1]) p1++;
         for (int k = 0; k < 10; k++) begin
            if (tbl[k].cyc == c) begin
               chk("tbl_slot_valid", 0, 8'(sv_w[0]), 8'(tbl[k].sv));
               chk("tbl_bank_num", 0, 8'(bank_w[0]), 8'(tbl[k].bank));
               chk("tbl_op_num", 0, 8'(op_w[0]), 8'(tbl[k].op));
               chk("tbl_last_slot", 0, 8'(last_w[0]), 8'(tbl[k].last));
               chk("tbl_busy", 0, 8'(busy_w[0]), 8'(tbl[k].busy));
               chk("tbl_done", 0, 8'(done_w[0]), 8'(tbl[k].done));
            end
         end
         if (c == 36) chk("fast_last_slot", 1, 8'(last_w[1]), 8'd1);
         if (c == 37) begin
            chk("fast_done", 1, 8'(done_w[1]), 8'd1);
            chk("fast_busy", 1, 8'(busy_w[1]), 8'd0);
         end
      end
      chk("pulse_count", 0, 8'(p0), 8'd36);
      chk("fast_pulse_count", 1, 8'(p1), 8'd36);

      // Overrun set/clear/set-wins, then a tick coincident with done.
      sample_clk_en = 1'b1;
      for (int c = 1; c <= 152; c++) begin
         step();
         sample_clk_en = (c == 50) || (c == 70) || (c == 149);
         overrun_clr   = (c == 60) || (c == 70);
         if (c == 51) chk("ovr_set", 0, 8'(ovr_w[0]), 8'd1);
         if (c == 53) begin
            chk("ovr_slot_valid", 0, 8'(sv_w[0]), 8'd1);
            chk("ovr_op_num", 0, 8'(op_w[0]), 8'd13);
         end
         if (c == 61) chk("ovr_clr", 0, 8'(ovr_w[0]), 8'd0);
         if (c == 71) chk("ovr_set_wins", 0, 8'(ovr_w[0]), 8'd1);
         if (c == 149) chk("ovr_done", 0, 8'(done_w[0]), 8'd1);
         if (c == 150) begin
            chk("restart_slot_valid", 0, 8'(sv_w[0]), 8'd1);
            chk("restart_bank_num", 0, 8'(bank_w[0]), 8'd0);
            chk("restart_op_num", 0, 8'(op_w[0]), 8'd0);
         end
      end
      drain(160);

      // Reset mid-sequence: immediate clear, no done, restart on a later tick.
      sample_clk_en = 1'b1;
      for (int c = 1; c <= 45; c++) begin
         step();
         sample_clk_en = (c == 40);
         reset = (c == 30);
         if (c == 30) begin
            #1;
            chk("rst_slot_valid", 0, 8'(sv_w[0]), 8'd0);
            chk("rst_bank_num", 0, 8'(bank_w[0]), 8'd0);
            chk("rst_op_num", 0, 8'(op_w[0]), 8'd0);
            chk("rst_busy", 0, 8'(busy_w[0]), 8'd0);
            chk("rst_last_slot", 0, 8'(last_w[0]), 8'd0);
            chk("rst_done", 0, 8'(done_w[0]), 8'd0);
         end
         if (c > 30 && c < 41) chk("rst_no_done", 0, 8'(done_w[0]), 8'd0);
         if (c == 41) begin
            chk("rst_restart_sv", 0, 8'(sv_w[0]), 8'd1);
            chk("rst_restart_op", 0, 8'(op_w[0]), 8'd0);
         end
      end
      drain(160);

      // enable dropped mid-sequence only blocks later starts.
      sample_clk_en = 1'b1;
      for (int c = 1; c <= 165; c++) begin
         step();
         sample_clk_en = (c == 160);
         if (c == 20) enable = 1'b0;
         if (c == 149) chk("en_done", 0, 8'(done_w[0]), 8'd1);
         if (c == 161) chk("en_no_slot", 0, 8'(sv_w[0]), 8'd0);
         if (c == 162) chk("en_no_overrun", 0, 8'(ovr_w[0]), 8'd0);
      end
      enable = 1'b1;

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         step();
         sample_clk_en = ($urandom_range(0, 29) == 0);
         enable        = ($urandom_range(0, 9) != 0);
         overrun_clr   = ($urandom_range(0, 15) == 0);
         reset         = ($urandom_range(0, 599) == 0);
      end
      reset = 1'b0;
      sample_clk_en = 1'b0;
      step();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/op_slot_sequencer.md
OP_SLOT_SEQUENCER -- requirements
Module: op_slot_sequencer

Interface
REQ-001 The block SHALL have parameter OP_SPACING, default 4: clocks between consecutive slot issues, legal range 1..15.
REQ-002 The block SHALL have parameter FLUSH_CYCLES, default 8: clocks from last slot issue to done, legal range 1..31.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-004 The block SHALL have port reset, input, 1 bit: reset is asynchronous and active-high.
REQ-005 The block SHALL have port sample_clk_en, input, 1 bit: one-cycle start-of-sample tick.
REQ-006 The block SHALL have port enable, input, 1 bit: when low, new ticks are ignored.
REQ-007 The block SHALL have port overrun_clr, input, 1 bit: clears the sticky overrun flag.
REQ-008 The block SHALL have port slot_valid, output, 1 bit: one-cycle strobe marking a slot issue.
REQ-009 The block SHALL have port bank_num, output, BANK_NUM_WIDTH bits: bank of the current slot.
REQ-010 The block SHALL have port op_num, output, OP_NUM_WIDTH bits: operator of the current slot.
REQ-011 The block SHALL have port last_slot, output, 1 bit: high with slot_valid for bank 1, operator 17.
REQ-012 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle end-of-sample pulse.
REQ-014 The block SHALL have port overrun, output, 1 bit: sticky flag set when a tick arrives while busy.

Function
REQ-015 The FSM SHALL have four states: IDLE, ISSUE, GAP, FLUSH.
REQ-016 In IDLE, the FSM SHALL go to ISSUE on the cycle after sample_clk_en && enable.
REQ-017 Slot order SHALL be bank 0 operators 0..17, then bank 1 operators 0..17, for 36 slots per sample.
REQ-018 In ISSUE, slot_valid SHALL be high for exactly one cycle; the FSM then enters GAP for OP_SPACING-1 cycles, or re-enters ISSUE directly when OP_SPACING=1.
REQ-019 Consecutive slot_valid pulses SHALL be exactly OP_SPACING cycles apart.
REQ-020 After the ISSUE cycle of the last slot, the FSM SHALL enter FLUSH.
REQ-021 done SHALL be high exactly FLUSH_CYCLES cycles after the last-slot cycle, in the cycle the FSM re-enters IDLE; busy SHALL be low in that cycle.
REQ-022 A tick coincident with done SHALL be accepted and start a new sequence.
REQ-023 bank_num and op_num SHALL be registered and SHALL hold the last issued slot between strobes.
REQ-024 bank_num and op_num SHALL be 0/0 while IDLE.
REQ-025 op_num SHALL wrap from 17 to 0 with a bank_num increment; bank_num SHALL never exceed 1.
REQ-026 A tick while busy SHALL be ignored and SHALL set overrun; the running sequence SHALL be unaffected.
REQ-027 overrun_clr SHALL clear overrun; if a set and overrun_clr occur in the same cycle, the set SHALL win.
REQ-028 enable falling mid-sequence SHALL NOT abort the sequence; it SHALL only block new starts.
REQ-029 A tick while enable is low SHALL NOT set overrun.
REQ-030 All outputs SHALL be driven from registers.

Reset
REQ-031 Asserting reset SHALL force the FSM to IDLE and drive slot_valid, last_slot, busy, done, overrun, bank_num and op_num to 0, immediately and asynchronously.
REQ-032 Reset asserted mid-sequence SHALL abandon the sequence with no done pulse.
REQ-033 After reset, the block SHALL accept a tick on the first cycle following reset deassertion.

Structure
REQ-034 NUM_BANKS (2) and NUM_OPERATORS_PER_BANK (18) SHALL live in opl3_pkg, reusing the existing BANK_NUM_WIDTH and OP_NUM_WIDTH.
REQ-035 The sequencer state enum typedef SHALL be added to opl3_pkg.
REQ-036 The block SHALL contain no sub-modules: one FSM, a spacing counter, a flush counter and a slot counter.

Verification
REQ-037 With defaults, tick at cycle 0: slot_valid at cycles 1,5,...,141 (36 pulses); last_slot at 141 with bank 1, op 17; done at 149; busy high in cycles 1..148.
REQ-038 With OP_SPACING=1 and FLUSH_CYCLES=1: slots at cycles 1..36 back-to-back, done at 37.
REQ-039 A second tick at cycle 50 with defaults: overrun=1, slot timing unchanged; overrun_clr at 60 clears it; overrun_clr together with a tick at 70 leaves overrun=1.
REQ-040 A tick at cycle 149, coincident with done: the next slot_valid at 150 with bank 0, op 0.
REQ-041 Reset pulse at cycle 30: all outputs 0 immediately; no done pulse follows; a tick at 40 restarts with the first slot at 41.
REQ-042 enable=0 at cycle 20 of a running sequence: sequence completes with done at 149; a tick at 160 produces no slot and overrun stays 0.
